// File: rtl/synth_pkg.sv
// synth_pkg
//   Definitions shared by the score sequencer, score images and the tops that
//   instantiate tone channels:
//     - default widths of a score entry (divisor, duration, address)
//     - bit layout of one score entry: {end, gate, div[DIV_W], dur[DUR_W]}
//     - sequencer state encoding
//     - tone divisor constants for divider_variable (A2..A6 plus C4)
//     - make_entry(): packs one score entry from its fields
package synth_pkg;

    localparam int SCORE_DIV_W   = 11;
    localparam int SCORE_DUR_W   = 8;
    localparam int SCORE_ADDR_W  = 9;
    localparam int SCORE_ENTRY_W = 2 + SCORE_DIV_W + SCORE_DUR_W;

    // Score entry layout, LSB first: duration, divisor, gate, end marker.
    localparam int DUR_LSB  = 0;
    localparam int DIV_LSB  = DUR_LSB + SCORE_DUR_W;
    localparam int GATE_BIT = DIV_LSB + SCORE_DIV_W;
    localparam int END_BIT  = GATE_BIT + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_PLAY  = 2'd3
    } seq_state_t;

    // Tone divisors for divider_variable; C4 is the post-reset divisor.
    localparam logic [SCORE_DIV_W-1:0] TONE_A2 = 11'd564;
    localparam logic [SCORE_DIV_W-1:0] TONE_A3 = 11'd282;
    localparam logic [SCORE_DIV_W-1:0] TONE_C4 = 11'd238;
    localparam logic [SCORE_DIV_W-1:0] TONE_A4 = 11'd141;
    localparam logic [SCORE_DIV_W-1:0] TONE_A5 = 11'd70;
    localparam logic [SCORE_DIV_W-1:0] TONE_A6 = 11'd35;

    function automatic logic [SCORE_ENTRY_W-1:0] make_entry(
        input logic                   is_end,
        input logic                   gate,
        input logic [SCORE_DIV_W-1:0] div,
        input logic [SCORE_DUR_W-1:0] dur
    );
        logic [SCORE_ENTRY_W-1:0] entry;
        entry                          = '0;
        entry[END_BIT]                 = is_end;
        entry[GATE_BIT]                = gate;
        entry[DIV_LSB +: SCORE_DIV_W]  = div;
        entry[DUR_LSB +: SCORE_DUR_W]  = dur;
        return entry;
    endfunction

endpackage

// File: rtl/score_sequencer.sv
// score_sequencer
//   Steps through a note score held in an external synchronous-read memory and
//   drives one tone channel (oe gate + divisor for divider_variable). Note
//   lengths are counted in external tempo ticks.
//
// Ports
//   clk          system clock, all logic on posedge
//   nRST         synchronous active-low reset
//   tick_en      tempo step pulse, 1 clk wide
//   start        begin playback at address 0 (restarts when already busy)
//   stop         abort playback; wins over start
//   loop_en      replay from address 0 when the end marker is reached
//   score_addr   score memory read address
//   score_rd     score memory read strobe (data valid the following cycle)
//   score_data   score entry {end, gate, div, dur}
//   oe           tone channel output enable
//   div_num      tone divisor
//   busy         high whenever the sequencer is not idle
//   note_strobe  one clk pulse per loaded note
module score_sequencer
    import synth_pkg::*;
#(
    parameter int               DIV_W    = SCORE_DIV_W,
    parameter int               DUR_W    = SCORE_DUR_W,
    parameter int               ADDR_W   = SCORE_ADDR_W,
    parameter logic [DIV_W-1:0] REST_DIV = TONE_C4
) (
    input  logic                     clk,
    input  logic                     nRST,
    input  logic                     tick_en,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    output logic [ADDR_W-1:0]        score_addr,
    output logic                     score_rd,
    input  logic [2+DIV_W+DUR_W-1:0] score_data,
    output logic                     oe,
    output logic [DIV_W-1:0]         div_num,
    output logic                     busy,
    output logic                     note_strobe
);

    // Field positions follow the same layout as the package, but are derived
    // from this instance's widths.
    localparam int F_DUR_LSB  = 0;
    localparam int F_DIV_LSB  = DUR_W;
    localparam int F_GATE_BIT = DUR_W + DIV_W;
    localparam int F_END_BIT  = DUR_W + DIV_W + 1;

    localparam logic [DUR_W-1:0]  DUR_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    seq_state_t         state_reg, state_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic               oe_reg, oe_next;
    logic [DIV_W-1:0]   div_reg, div_next;
    logic [DUR_W-1:0]   remaining_reg, remaining_next;
    logic               strobe_reg, strobe_next;

    logic               entry_end;
    logic               entry_gate;
    logic [DIV_W-1:0]   entry_div;
    logic [DUR_W-1:0]   entry_dur;

    assign entry_end  = score_data[F_END_BIT];
    assign entry_gate = score_data[F_GATE_BIT];
    assign entry_div  = score_data[F_DIV_LSB +: DIV_W];
    assign entry_dur  = score_data[F_DUR_LSB +: DUR_W];

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            oe_reg        <= 1'b0;
            div_reg       <= REST_DIV;
            remaining_reg <= '0;
            strobe_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            oe_reg        <= oe_next;
            div_reg       <= div_next;
            remaining_reg <= remaining_next;
            strobe_reg    <= strobe_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        oe_next        = oe_reg;
        div_next       = div_reg;
        remaining_next = remaining_reg;
        strobe_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                oe_next = 1'b0;
            end
            ST_FETCH: begin
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (entry_end) begin
                    // An end marker at address 0 must not loop, otherwise an
                    // empty score would spin forever.
                    if (loop_en && (addr_reg != '0)) begin
                        addr_next  = '0;
                        state_next = ST_FETCH;
                    end else begin
                        oe_next    = 1'b0;
                        state_next = ST_IDLE;
                    end
                end else if (entry_dur == '0) begin
                    addr_next  = addr_reg + ADDR_ONE;
                    state_next = ST_FETCH;
                end else begin
                    // Divisor is taken even for a gated-off note so the
                    // divider is already settled when the next gate opens.
                    oe_next        = entry_gate;
                    div_next       = entry_div;
                    remaining_next = entry_dur;
                    strobe_next    = 1'b1;
                    state_next     = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (tick_en) begin
                    remaining_next = remaining_reg - DUR_ONE;
                    if (remaining_reg == DUR_ONE) begin
                        addr_next  = addr_reg + ADDR_ONE;
                        state_next = ST_FETCH;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Restart: the current entry (if any is being loaded) is discarded and
        // the outputs keep their values until address 0 has been loaded.
        if (start) begin
            addr_next      = '0;
            state_next     = ST_FETCH;
            oe_next        = oe_reg;
            div_next       = div_reg;
            remaining_next = remaining_reg;
            strobe_next    = 1'b0;
        end

        if (stop) begin
            addr_next      = addr_reg;
            state_next     = ST_IDLE;
            oe_next        = 1'b0;
            div_next       = div_reg;
            remaining_next = '0;
            strobe_next    = 1'b0;
        end
    end

    assign score_addr  = addr_reg;
    assign score_rd    = (state_reg == ST_FETCH);
    assign oe          = oe_reg;
    assign div_num     = div_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign note_strobe = strobe_reg;

endmodule
